credit_rx_vcbuf: RTL and testbench

CREDIT_RX_VCBUF -- requirements
Module: credit_rx_vcbuf

---
 rtl/credit_rx_vcbuf.sv | 155 +++++++++++++++
 tb/tb_credit_rx_vcbuf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_rx_vcbuf.sv
// Credit-based receive buffer: one FWFT FIFO per virtual channel plus an output arbiter.
// Define CREDIT_RX_VCBUF_OVF_CHECK_EN to build the sticky overflow flag on o_err.
module credit_rx_vcbuf #(
    parameter int NUM_VC   = 2,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int D_W      = 8,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_VC-1:0]                    i_vc_target,
    input  logic [X_W-1:0]                       i_x,
    input  logic [Y_W-1:0]                       i_y,
    input  logic [D_W-1:0]                       i_d,
    output logic [NUM_VC-1:0]                    o_vc_credit_gnt,
    output logic [NUM_VC-1:0]                    o_v,
    output logic [X_W-1:0]                       o_x,
    output logic [Y_W-1:0]                       o_y,
    output logic [D_W-1:0]                       o_d,
    input  logic                                 i_b,
    output logic [NUM_VC*$clog2(DEPTH+1)-1:0]    o_occ,
    output logic                                 o_err
);

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int FLIT_W = X_W + Y_W + D_W;

    logic [FLIT_W-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [OCC_W-1:0]  occ    [NUM_VC];

    logic [VC_W-1:0]   rr_ptr;
    logic [VC_W-1:0]   hold_vc;
    logic              hold_valid;
    logic [VC_W-1:0]   arb_vc;
    logic              arb_found;
    logic [VC_W-1:0]   sel_vc;
    logic              sel_valid;
    logic              handshake;
    logic [NUM_VC-1:0] non_empty;
    logic [NUM_VC-1:0] push_ok;
    logic [NUM_VC-1:0] pop;
    logic [FLIT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            non_empty[v] = rst && (occ[v] != '0);
        end
    end

    // Search order starts at rr_ptr in round-robin mode, at VC0 in fixed-priority mode.
    always_comb begin
        arb_found = 1'b0;
        arb_vc    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            int idx;
            idx = (ARB_MODE == 1) ? i : (int'(rr_ptr) + i) % NUM_VC;
            if (!arb_found && non_empty[idx]) begin
                arb_found = 1'b1;
                arb_vc    = VC_W'(idx);
            end
        end
    end

    // A grant held over backpressure takes precedence over a fresh arbitration result.
    always_comb begin
        sel_valid = rst && (hold_valid || arb_found);
        sel_vc    = hold_valid ? hold_vc : arb_vc;
        handshake = sel_valid && !i_b;
        head      = mem[sel_vc][rd_ptr[sel_vc]];
        for (int v = 0; v < NUM_VC; v++) begin
            o_v[v]     = sel_valid && (sel_vc == VC_W'(v));
            pop[v]     = handshake && (sel_vc == VC_W'(v));
            push_ok[v] = rst && i_vc_target[v] && ((occ[v] != OCC_W'(DEPTH)) || pop[v]);
        end
        o_vc_credit_gnt = pop;
        {o_x, o_y, o_d} = sel_valid ? head : '0;
    end

    always_comb begin
        o_occ = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            o_occ[v*OCC_W +: OCC_W] = rst ? occ[v] : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_ok[v]) begin
                mem[v][wr_ptr[v]] <= {i_x, i_y, i_d};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                occ[v]    <= '0;
            end
            rr_ptr     <= '0;
            hold_vc    <= '0;
            hold_valid <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_ok[v]) begin
                    wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                end
                if (pop[v]) begin
                    rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                end
                case ({push_ok[v], pop[v]})
                    2'b10:   occ[v] <= occ[v] + OCC_W'(1);
                    2'b01:   occ[v] <= occ[v] - OCC_W'(1);
                    default: occ[v] <= occ[v];
                endcase
            end
            if (handshake && (ARB_MODE == 0)) begin
                rr_ptr <= (sel_vc == VC_W'(NUM_VC - 1)) ? '0 : sel_vc + VC_W'(1);
            end
            hold_valid <= sel_valid && i_b;
            hold_vc    <= sel_vc;
        end
    end

`ifdef CREDIT_RX_VCBUF_OVF_CHECK_EN
    logic err_q;
    logic ovf;

    assign ovf = rst && (|(i_vc_target & ~push_ok));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (ovf) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_rx_vcbuf.sv
// Randomised and directed bench for credit_rx_vcbuf: a round-robin DEPTH=3 instance and a
// fixed-priority DEPTH=4 instance share stimulus and are checked against queue-based models.
module tb_credit_rx_vcbuf;

`ifdef CREDIT_RX_VCBUF_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tgt;
    logic [3:0] in_x, in_y;
    logic [7:0] in_d;
    logic       in_b;

    logic [1:0] rr_gnt, rr_v, fp_gnt, fp_v;
    logic [3:0] rr_x, rr_y, fp_x, fp_y;
    logic [7:0] rr_d, fp_d;
    logic [3:0] rr_occ;
    logic [5:0] fp_occ;
    logic       rr_err, fp_err;

    logic [1:0]  v_o    [2];
    logic [1:0]  gnt_o  [2];
    logic [15:0] flit_o [2];
    logic [5:0]  occ_o  [2];
    logic        err_o  [2];

    int n_cmp;
    int n_bad;

    logic [15:0] mq [4][$];
    bit          held    [2];
    int          held_vc [2];
    int          rr      [2];
    bit          merr    [2];
    bit          undef   [2];

    always #5 clk = ~clk;

    credit_rx_vcbuf #(.NUM_VC(2), .X_W(4), .Y_W(4), .D_W(8), .DEPTH(3), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .i_vc_target(tgt), .i_x(in_x), .i_y(in_y), .i_d(in_d),
        .o_vc_credit_gnt(rr_gnt), .o_v(rr_v), .o_x(rr_x), .o_y(rr_y), .o_d(rr_d),
        .i_b(in_b), .o_occ(rr_occ), .o_err(rr_err)
    );

    credit_rx_vcbuf #(.NUM_VC(2), .X_W(4), .Y_W(4), .D_W(8), .DEPTH(4), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .i_vc_target(tgt), .i_x(in_x), .i_y(in_y), .i_d(in_d),
        .o_vc_credit_gnt(fp_gnt), .o_v(fp_v), .o_x(fp_x), .o_y(fp_y), .o_d(fp_d),
        .i_b(in_b), .o_occ(fp_occ), .o_err(fp_err)
    );

    assign v_o[0]    = rr_v;
    assign v_o[1]    = fp_v;
    assign gnt_o[0]  = rr_gnt;
    assign gnt_o[1]  = fp_gnt;
    assign flit_o[0] = {rr_x, rr_y, rr_d};
    assign flit_o[1] = {fp_x, fp_y, fp_d};
    assign occ_o[0]  = {2'b00, rr_occ};
    assign occ_o[1]  = fp_occ;
    assign err_o[0]  = rr_err;
    assign err_o[1]  = fp_err;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    // Which VC the spec says is presented this cycle, or -1 if none.
    function automatic int pick(input int k);
        if (held[k]) return held_vc[k];
        for (int i = 0; i < 2; i++) begin
            int v;
            v = (k == 0) ? (rr[k] + i) % 2 : i;
            if (mq[k*2+v].size() > 0) return v;
        end
        return -1;
    endfunction

    task automatic modelUpdate();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mq[k*2].delete();
                mq[k*2+1].delete();
                held[k]  = 1'b0;
                rr[k]    = 0;
                merr[k]  = 1'b0;
                undef[k] = 1'b0;
            end else begin
                int s;
                s = pick(k);
                if (s >= 0 && !in_b) begin
                    void'(mq[k*2+s].pop_front());
                    rr[k]   = (s + 1) % 2;
                    held[k] = 1'b0;
                end else begin
                    held[k]    = (s >= 0);
                    held_vc[k] = s;
                end
                for (int v = 0; v < 2; v++) begin
                    if (tgt[v]) begin
                        if (mq[k*2+v].size() < depth_of(k)) mq[k*2+v].push_back({in_x, in_y, in_d});
                        else if (OVF_EN) merr[k] = 1'b1;
                        else undef[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic modelCheck();
        for (int k = 0; k < 2; k++) begin
            int s, ev, eg, ef, eo, sh;
            if (undef[k]) continue;
            s  = rst ? pick(k) : -1;
            ev = (s >= 0) ? (1 << s) : 0;
            eg = (s >= 0 && !in_b) ? ev : 0;
            ef = (s >= 0) ? int'(mq[k*2+s][0]) : 0;
            sh = (k == 0) ? 2 : 3;
            eo = rst ? ((mq[k*2+1].size() << sh) | mq[k*2].size()) : 0;
            checkOutput($sformatf("m%0d_v", k), 32'(v_o[k]), ev);
            checkOutput($sformatf("m%0d_gnt", k), 32'(gnt_o[k]), eg);
            checkOutput($sformatf("m%0d_flit", k), 32'(flit_o[k]), ef);
            checkOutput($sformatf("m%0d_occ", k), 32'(occ_o[k]), eo);
            if (rst) checkOutput($sformatf("m%0d_err", k), 32'(err_o[k]), 32'(merr[k]));
        end
    endtask

    // Model follows the edge, new inputs go on at the falling edge, outputs are sampled 1ns later.
    task automatic applyStimulus(input bit r, input logic [1:0] t, input logic [15:0] f,
                                 input bit b, input bit safe);
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        if (safe) begin
            for (int v = 0; v < 2; v++)
                for (int k = 0; k < 2; k++)
                    if (mq[k*2+v].size() >= depth_of(k)) t[v] = 1'b0;
        end
        rst = r;
        tgt = t;
        {in_x, in_y, in_d} = f;
        in_b = b;
        #1;
        modelCheck();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; tgt = '0; in_x = '0; in_y = '0; in_d = '0; in_b = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b11, 16'h1234, 0, 0);
        checkOutput("rst_occ_rr", 32'(rr_occ), 0);
        checkOutput("rst_v_fp", 32'(fp_v), 0);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("rst_discard_occ", 32'(fp_occ), 0);

        applyStimulus(1, 2'b01, 16'h12A5, 0, 0);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("first_v", 32'(fp_v), 32'h1);
        checkOutput("first_d", 32'(fp_d), 32'hA5);
        checkOutput("first_gnt", 32'(fp_gnt), 32'h1);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("first_occ", 32'(fp_occ), 0);

        applyStimulus(0, 2'b00, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'b11, 16'(16'h3000 + i), 1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 2'b00, 16'h0, 0, 0);
            checkOutput("rr_alternate", 32'(rr_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("fp_order", 32'(fp_gnt), (i < 3) ? 32'h1 : 32'h2);
        end

        applyStimulus(0, 2'b00, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'b10, 16'(16'h3411 + i), 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, (i < 2) ? 2'b01 : 2'b00, 16'(16'h5500 + i), 1, 0);
            checkOutput("hold_v", 32'(rr_v), 32'h2);
            checkOutput("hold_d", 32'({rr_x, rr_y, rr_d}), 32'h3411);
            checkOutput("hold_gnt", 32'(rr_gnt), 0);
        end
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("release_rr", 32'(rr_gnt), 32'h2);
        checkOutput("release_fp", 32'(fp_gnt), 32'h2);
        for (int i = 0; i < 8; i++) applyStimulus(1, 2'b00, 16'h0, 0, 0);

        applyStimulus(0, 2'b00, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 2'b01, 16'(16'h6600 + i), 1, 0);
        applyStimulus(1, 2'b01, 16'h6603, 0, 0);
        applyStimulus(1, 2'b01, 16'h6604, 1, 0);
        checkOutput("full_pushpop_occ", 32'(rr_occ[1:0]), 32'h3);
        checkOutput("full_pushpop_err", 32'(rr_err), 0);
        applyStimulus(1, 2'b00, 16'h0, 1, 0);
        checkOutput("overflow_err", 32'(rr_err), 32'(OVF_EN));
        applyStimulus(1, 2'b00, 16'h0, 1, 0);
        checkOutput("overflow_sticky", 32'(rr_err), 32'(OVF_EN));

        applyStimulus(0, 2'b00, 16'h0, 0, 0);
        applyStimulus(1, 2'b11, 16'h7700, 1, 0);
        applyStimulus(1, 2'b11, 16'h7701, 1, 0);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("fp_drain0", 32'(fp_gnt), 32'h1);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("fp_drain1", 32'(fp_gnt), 32'h1);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("fp_drain2", 32'(fp_gnt), 32'h2);
        applyStimulus(0, 2'b00, 16'h0, 0, 0);
        checkOutput("midrst_v", 32'(fp_v), 0);
        checkOutput("midrst_gnt", 32'(fp_gnt), 0);
        applyStimulus(1, 2'b00, 16'h0, 0, 0);
        checkOutput("midrst_occ", 32'(fp_occ), 0);
        checkOutput("midrst_v_after", 32'(fp_v), 0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 63) != 0, 2'($urandom), 16'($urandom),
                          $urandom_range(0, 2) == 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
